dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 32-bit-block data memory.
- Produces READDATA, which the writeback mux feeds to the register-file IN port.
- Produces BUSYWAIT, which stalls the PC and gates register-file writes.
- Geometry is fixed: 8 sets x 4 bytes (32 B total). Address split: tag[7:5], index[4:2], offset[1:0].

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_if.sv | 28 ++
 rtl/dcache_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
// Geometry is fixed at 8 lines of 4 bytes behind an 8-bit byte address.
package dcache_pkg;
  localparam int DATA_W     = 8;
  localparam int NUM_SETS   = 8;
  localparam int BLOCK_W    = 32;
  localparam int ADDR_W     = 8;

  localparam int TAG_MSB    = 7;
  localparam int TAG_LSB    = 5;
  localparam int IDX_MSB    = 4;
  localparam int IDX_LSB    = 2;
  localparam int OFF_MSB    = 1;
  localparam int OFF_LSB    = 0;

  localparam int TAG_W      = TAG_MSB - TAG_LSB + 1;
  localparam int IDX_W      = IDX_MSB - IDX_LSB + 1;
  localparam int MEM_ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;
endpackage

// File: rtl/dcache_if.sv
// CPU load/store port and block-memory port of the data cache.
// The cache connects through the slave modport; the CPU/memory side through master.
interface dcache_if;
  import dcache_pkg::*;

  logic                  READ;
  logic                  WRITE;
  logic [ADDR_W-1:0]     ADDRESS;
  logic [DATA_W-1:0]     WRITEDATA;
  logic [DATA_W-1:0]     READDATA;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: line storage, hit logic
// and the miss-handling FSM (write back dirty victim, fetch, allocate).
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic     CLK,
  input  logic     RESET,
  dcache_if.slave  bus
);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [BLOCK_W-1:0]  r_data [NUM_SETS];
  logic [BLOCK_W-1:0]  r_fill;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_off;
  logic [BLOCK_W-1:0]    w_line;
  logic                  w_hit;
  logic                  w_req;
  logic                  w_store_hit;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic [MEM_ADDR_W-1:0] w_mem_addr;
  logic [BLOCK_W-1:0]    w_mem_wdata;

  assign w_tag  = bus.ADDRESS[TAG_MSB:TAG_LSB];
  assign w_idx  = bus.ADDRESS[IDX_MSB:IDX_LSB];
  assign w_off  = bus.ADDRESS[OFF_MSB:OFF_LSB];
  assign w_line = r_data[w_idx];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_req  = bus.READ | bus.WRITE;
  // READ and WRITE together behave as a store, so only WRITE selects the store path
  assign w_store_hit = (r_state == IDLE) && bus.WRITE && w_hit;

  assign bus.READDATA      = w_line[{w_off, 3'b000} +: DATA_W];
  assign bus.BUSYWAIT      = w_req && !((r_state == IDLE) && w_hit);
  assign bus.MEM_READ      = w_mem_read;
  assign bus.MEM_WRITE     = w_mem_write;
  assign bus.MEM_ADDRESS   = w_mem_addr;
  assign bus.MEM_WRITEDATA = w_mem_wdata;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        w_mem_write = 1'b1;
        w_mem_addr  = {r_tag[w_idx], w_idx};
        w_mem_wdata = r_data[w_idx];
        if (!bus.MEM_BUSYWAIT) w_next = FETCH;
      end
      FETCH: begin
        w_mem_read = 1'b1;
        w_mem_addr = bus.ADDRESS[TAG_MSB:IDX_LSB];
        if (!bus.MEM_BUSYWAIT) w_next = ALLOCATE;
      end
      ALLOCATE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Line status bits are the only storage cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == ALLOCATE) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_store_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == FETCH && !bus.MEM_BUSYWAIT) r_fill <= bus.MEM_READDATA;
    if (r_state == ALLOCATE) begin
      r_data[w_idx] <= r_fill;
      r_tag[w_idx]  <= w_tag;
    end else if (w_store_hit) begin
      r_data[w_idx][{w_off, 3'b000} +: DATA_W] <= bus.WRITEDATA;
    end
  end

endmodule
